// File: rtl/ddr3_axi_pkg.sv
// Shared FSM state encoding and AXI burst-length width for the DDR3 AXI burst engine.
package ddr3_axi_pkg;

    localparam int AXI_LEN_W = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_AW   = 3'd1;
    localparam logic [2:0] ST_WR_DATA = 3'd2;
    localparam logic [2:0] ST_WR_FIN  = 3'd3;
    localparam logic [2:0] ST_RD_AR   = 3'd4;
    localparam logic [2:0] ST_RD_DATA = 3'd5;
    localparam logic [2:0] ST_RD_FIN  = 3'd6;

endpackage

// File: rtl/ddr3_burst_splitter.sv
// Combinational burst sizing: beats = min(remaining, distance to next BURST_MAX boundary).
// Zero latency; no handshake, outputs are only meaningful while remaining is non-zero.
module ddr3_burst_splitter
    import ddr3_axi_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int LEN_W     = 10,
    parameter int BURST_MAX = 16
) (
    input  logic [ADDR_W-1:0]    addr,
    input  logic [LEN_W-1:0]     remaining,
    output logic [AXI_LEN_W-1:0] axlen,
    output logic [ADDR_W-1:0]    next_addr,
    output logic [LEN_W-1:0]     next_remaining
);

    localparam int OFS_W = $clog2(BURST_MAX);
    localparam int CNT_W = (LEN_W > OFS_W + 1) ? LEN_W : OFS_W + 1;

    logic [CNT_W-1:0] to_boundary;
    logic [CNT_W-1:0] rem_ext;
    logic [CNT_W-1:0] beats;

    always_comb begin
        to_boundary    = CNT_W'(BURST_MAX) - CNT_W'(addr[OFS_W-1:0]);
        rem_ext        = CNT_W'(remaining);
        beats          = (rem_ext < to_boundary) ? rem_ext : to_boundary;
        axlen          = AXI_LEN_W'(beats - CNT_W'(1));
        next_addr      = addr + ADDR_W'(beats);
        next_remaining = remaining - LEN_W'(beats);
    end

endmodule

// File: rtl/ddr3_axi_burst_engine.sv
// Turns DDR3 read/write requests into boundary-aligned AXI4 bursts; write data flows FIFO->AXI combinationally,
// read data AXI->FIFO with one register stage. AW/AR/W wait on ready; R is always accepted.
module ddr3_axi_burst_engine
    import ddr3_axi_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 256,
    parameter int LEN_W     = 10,
    parameter int BURST_MAX = 16,
    parameter int FIN_GAP   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wd_req,
    input  logic [ADDR_W-1:0]    wd_addr,
    input  logic [LEN_W-1:0]     wd_len,
    output logic                 wd_finish,
    input  logic                 rd_req,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [LEN_W-1:0]     rd_len,
    output logic                 rd_finish,
    output logic                 wfifo_rd_en,
    input  logic [DATA_W-1:0]    wfifo_rdata,
    output logic                 rfifo_wr_en,
    output logic [DATA_W-1:0]    rfifo_wdata,
    output logic [ADDR_W-1:0]    axi_awaddr,
    output logic [AXI_LEN_W-1:0] axi_awlen,
    output logic                 axi_awvalid,
    input  logic                 axi_awready,
    output logic [DATA_W-1:0]    axi_wdata,
    output logic                 axi_wlast,
    output logic                 axi_wvalid,
    input  logic                 axi_wready,
    output logic [ADDR_W-1:0]    axi_araddr,
    output logic [AXI_LEN_W-1:0] axi_arlen,
    output logic                 axi_arvalid,
    input  logic                 axi_arready,
    input  logic [DATA_W-1:0]    axi_rdata,
    input  logic                 axi_rlast,
    input  logic                 axi_rvalid
);

    localparam int GAP_W = $clog2(FIN_GAP + 2);

    state_t               state;
    logic [ADDR_W-1:0]    addr_q;
    logic [LEN_W-1:0]     rem_q;
    logic [AXI_LEN_W-1:0] cnt_q;
    logic [GAP_W-1:0]     gap_q;

    logic [AXI_LEN_W-1:0] split_len;
    logic [ADDR_W-1:0]    split_addr;
    logic [LEN_W-1:0]     split_rem;
    logic                 rd_beat;

    ddr3_burst_splitter #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .BURST_MAX (BURST_MAX)
    ) u_splitter (
        .addr           (addr_q),
        .remaining      (rem_q),
        .axlen          (split_len),
        .next_addr      (split_addr),
        .next_remaining (split_rem)
    );

    // Outputs decode from state and are forced to zero outside their phase so reset clears them at once.
    always_comb begin
        axi_awvalid = (state == ST_WR_AW);
        axi_awaddr  = axi_awvalid ? addr_q : '0;
        axi_awlen   = axi_awvalid ? split_len : '0;
        axi_wvalid  = (state == ST_WR_DATA);
        axi_wdata   = axi_wvalid ? wfifo_rdata : '0;
        axi_wlast   = axi_wvalid && (cnt_q == '0);
        wfifo_rd_en = axi_wvalid && axi_wready;
        axi_arvalid = (state == ST_RD_AR);
        axi_araddr  = axi_arvalid ? addr_q : '0;
        axi_arlen   = axi_arvalid ? split_len : '0;
        wd_finish   = (state == ST_WR_FIN);
        rd_finish   = (state == ST_RD_FIN);
        rd_beat     = (state == ST_RD_DATA) && axi_rvalid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            gap_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GAP_W'(1);
                    end else if (wd_req) begin
                        addr_q <= wd_addr;
                        rem_q  <= wd_len;
                        state  <= (wd_len == '0) ? ST_WR_FIN : ST_WR_AW;
                    end else if (rd_req) begin
                        addr_q <= rd_addr;
                        rem_q  <= rd_len;
                        state  <= (rd_len == '0) ? ST_RD_FIN : ST_RD_AR;
                    end
                end
                // addr_q/rem_q advance at the address handshake; the data phase only needs the beat count.
                ST_WR_AW: begin
                    if (axi_awready) begin
                        cnt_q  <= split_len;
                        addr_q <= split_addr;
                        rem_q  <= split_rem;
                        state  <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (axi_wready) begin
                        if (cnt_q == '0) begin
                            state <= (rem_q == '0) ? ST_WR_FIN : ST_WR_AW;
                        end else begin
                            cnt_q <= cnt_q - AXI_LEN_W'(1);
                        end
                    end
                end
                ST_RD_AR: begin
                    if (axi_arready) begin
                        addr_q <= split_addr;
                        rem_q  <= split_rem;
                        state  <= ST_RD_DATA;
                    end
                end
                // rlast, not the beat count, closes a read burst.
                ST_RD_DATA: begin
                    if (axi_rvalid && axi_rlast) begin
                        state <= (rem_q == '0) ? ST_RD_FIN : ST_RD_AR;
                    end
                end
                ST_WR_FIN, ST_RD_FIN: begin
                    gap_q <= GAP_W'(FIN_GAP);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rfifo_wr_en <= 1'b0;
            rfifo_wdata <= '0;
        end else begin
            rfifo_wr_en <= rd_beat;
            if (rd_beat) begin
                rfifo_wdata <= axi_rdata;
            end
        end
    end

endmodule
